beta_mul_seq: RTL
=================

Name: beta_mul_seq

Overview:
Iterative radix-2 shift-add unsigned multiplier for the Beta ALU MUL path. It sits downstream of the ALU operand muxes, alongside the 32-bit CLA adder. Each cycle it performs one partial-sum accumulation through a wide add and returns the full 2*WIDTH-bit product over a valid/ready handshake. The ALU result mux uses p_lo; p_hi is kept for future MULH support.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  in  1  operands a/b valid
in_ready  out  1  block can accept operands; high only in IDLE
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
out_valid  out  1  product valid; high only in DONE
out_ready  in  1  consumer accepts product
p_lo  out  WIDTH  product bits [WIDTH-1:0]
p_hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]
busy  out  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Registered state, counter cnt (clog2(WIDTH) bits), acc (2*WIDTH), mcand (2*WIDTH), mplier (WIDTH).
- Reset (rst_n low at an edge): state=IDLE, acc=0, cnt=0, out_valid=0, busy=0, p_lo=p_hi=0. in_ready is 0 while rst_n is low and 1 from the first cycle after release.
- Reset mid-RUN or mid-DONE aborts the operation. No partial product is ever presented.
- IDLE: in_ready=1. On in_valid&&in_ready: mcand={0,a}, mplier=b, acc=0, cnt=0, go to RUN.
- RUN: one step per cycle:
  - if mplier[0], acc <= acc + mcand (2*WIDTH-bit add, carry-out discarded; cannot overflow for unsigned operands);
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - Exit to DONE after the step with cnt==WIDTH-1.
- DONE: out_valid=1; {p_hi,p_lo} = acc. Hold all outputs stable while out_ready=0. On out_ready, go to IDLE.
- p_lo/p_hi retain the last product in IDLE, until the next accept or reset.
- Latency: accept in cycle k. RUN occupies cycles k+1..k+WIDTH. out_valid is high from cycle k+WIDTH+1.
- Throughput: one result per WIDTH+2 cycles minimum. The DONE->IDLE transition costs one cycle, and accept is only possible in IDLE. No overlap between output handshake and input accept.
- in_valid in RUN/DONE is ignored (in_ready=0). a/b need only be stable in the accept cycle.
- out_ready in IDLE/RUN is ignored.
- Unsigned multiply. The ALU takes the low WIDTH bits, which are also the correct two's-complement low word.

Optional Feature:
MUL_EARLY_EXIT_EN
- Defined:
  - RUN exits to DONE after the step where the shifted mplier becomes 0, or when cnt==WIDTH-1, whichever comes first.
  - If b==0 at accept, go directly IDLE->DONE with acc=0.
  - Latency: m+1 RUN cycles, where m = index of the highest set bit of b. out_valid is high from cycle k+m+2, or k+1 for b==0.
- Undefined: fixed WIDTH RUN cycles as above. Product values are identical in both builds.

Test Plan:
1. a=3, b=5, accept cycle k -> out_valid first high at k+33 (fixed build); p_hi=0, p_lo=15.
2. a=b=0xFFFFFFFF -> p_hi=0xFFFFFFFE, p_lo=0x00000001; separately a=b=0x00010000 -> p_hi=1, p_lo=0.
3. After a=7, b=6 completes, hold out_ready=0 for 10 cycles while driving in_valid with a=2, b=2 -> out_valid, p_lo=42 stable; in_ready=0; second operation not accepted until one cycle after the out_ready handshake.
4. Drop rst_n for one edge at cycle k+10 of a 0x1234*0x5678 run -> next cycle out_valid=0, busy=0, p_lo=p_hi=0, in_ready=1 after release. Then 7*6 -> p_lo=42 at the normal latency.
5. MUL_EARLY_EXIT_EN defined: a=0x12345678, b=0 -> out_valid at k+1, product 0; a=9, b=4 -> out_valid at k+4, p_lo=36; b=0x80000000 -> out_valid at k+33. Undefined build: all three at k+33 with the same products.
6. Back-to-back: in_valid held high with a=i, b=i+1 for i=1..4, out_ready=1 -> four products 2, 6, 12, 20 in order, spaced exactly WIDTH+2 cycles apart (fixed build).

Source files
------------

// File: rtl/beta_mul_seq.sv
// beta_mul_seq: iterative radix-2 shift-add unsigned multiplier for the Beta
// ALU MUL path. One partial-sum accumulation per cycle through a 2*WIDTH-bit
// add; the full 2*WIDTH-bit product is returned over a valid/ready handshake.
//
// Optional build macro: MUL_EARLY_EXIT_EN
//   defined   - RUN ends as soon as the remaining multiplier bits are all zero,
//               and b==0 at accept goes straight to DONE with a zero product.
//   undefined - RUN always takes exactly WIDTH cycles.
// The product value is the same in both builds; only the latency changes.

module beta_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_lo,
    output logic [WIDTH-1:0] p_hi,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [PW-1:0]  acc, acc_next;
    logic [PW-1:0]  mcand, mcand_next;
    logic [WIDTH-1:0] mplier, mplier_next;
    // Product register: loaded only when a result is complete, so the
    // outputs never show a partial sum and keep the last product in IDLE.
    logic [PW-1:0]  prod, prod_next;

    // Step datapath shared by the RUN state.
    logic [PW-1:0]    step_sum;
    logic [WIDTH-1:0] mplier_shift;
    logic             last_step;

    // Combinational partial-sum step and exit condition.
    always_comb begin
        step_sum     = mplier[0] ? (acc + mcand) : acc;
        mplier_shift = mplier >> 1;
`ifdef MUL_EARLY_EXIT_EN
        last_step    = (cnt == CNT_LAST) || (mplier_shift == '0);
`else
        last_step    = (cnt == CNT_LAST);
`endif
    end

    // Next-state and datapath-update logic for the IDLE/RUN/DONE FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_next  = state;
        cnt_next    = cnt;
        acc_next    = acc;
        mcand_next  = mcand;
        mplier_next = mplier;
        prod_next   = prod;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    mcand_next  = {{WIDTH{1'b0}}, a};
                    mplier_next = b;
                    acc_next    = '0;
                    cnt_next    = '0;
`ifdef MUL_EARLY_EXIT_EN
                    if (b == '0) begin
                        prod_next  = '0;
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
`else
                    state_next  = RUN;
`endif
                end
            end

            RUN: begin
                acc_next    = step_sum;
                mcand_next  = mcand << 1;
                mplier_next = mplier_shift;
                cnt_next    = cnt + CW'(1);
                if (last_step) begin
                    prod_next  = step_sum;
                    state_next = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            acc    <= acc_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            prod   <= prod_next;
        end
    end

    // Handshake and status outputs decoded from the state register; in_ready
    // is also gated by rst_n so nothing is offered while reset is asserted.
    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign p_lo      = prod[WIDTH-1:0];
    assign p_hi      = prod[PW-1:WIDTH];

endmodule
